// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy initiator: one read cycle then one write cycle per word,
// walking src/dst upward by STRIDE bytes until the count runs out or abort is seen.
module mem_copy_engine #(
  parameter int ADDR_W       = 32,
  parameter int CNT_W        = 16,
  parameter int STRIDE       = 4,
  parameter bit DUMP_ON_DONE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  words_copied,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data_in,
  input  logic [31:0]       mem_data_out,
  output logic              mem_createdump
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(STRIDE);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  cpy_q, cpy_d;
  logic [31:0]       buf_q, buf_d;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    cpy_d   = cpy_q;
    buf_d   = buf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          rem_d   = word_count;
          cpy_d   = '0;
          state_d = (word_count == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        buf_d   = mem_data_out;
        state_d = abort ? S_DONE : S_WRITE;
      end
      S_WRITE: begin
        // the write in flight always lands, so bookkeeping advances even on abort
        src_d   = src_q + STEP;
        dst_d   = dst_q + STEP;
        rem_d   = rem_q - 1'b1;
        cpy_d   = cpy_q + 1'b1;
        state_d = (rem_q == CNT_W'(1) || abort) ? S_DONE : S_READ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      cpy_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      cpy_q   <= cpy_d;
      buf_q   <= buf_d;
    end
  end

  // memory side decodes from registered state only
  always_comb begin
    busy           = (state_q == S_READ) || (state_q == S_WRITE);
    done           = (state_q == S_DONE);
    mem_enable     = busy;
    mem_wr         = (state_q == S_WRITE);
    mem_createdump = done && DUMP_ON_DONE;
    mem_addr       = '0;
    mem_data_in    = '0;
    if (state_q == S_READ) mem_addr = src_q;
    if (state_q == S_WRITE) begin
      mem_addr    = dst_q;
      mem_data_in = buf_q;
    end
  end

  assign words_copied = cpy_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a small word-indexed memory model.
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] word_count;
  logic        busy, done, mem_enable, mem_wr, mem_createdump;
  logic [15:0] words_copied;
  logic [31:0] mem_addr, mem_data_in, mem_data_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [0:1023];
  logic [31:0] rd_addrs [$];

  mem_copy_engine #(.ADDR_W(32), .CNT_W(16), .STRIDE(4), .DUMP_ON_DONE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .word_count(word_count), .abort(abort), .busy(busy), .done(done),
    .words_copied(words_copied), .mem_enable(mem_enable), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_createdump(mem_createdump)
  );

  always #5 clk = ~clk;

  assign mem_data_out = mem[mem_addr[11:2]];

  always @(posedge clk)
    if (mem_enable && mem_wr) mem[mem_addr[11:2]] <= mem_data_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // dump request must track done exactly
  always @(negedge clk) if (rst_n) chk("dump_eq_done", {31'b0, mem_createdump}, {31'b0, done});

  function automatic logic [31:0] rdm(input logic [31:0] a);
    return mem[a[11:2]];
  endfunction

  task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                     input int abort_rd, input bit poke, output int done_cyc,
                     output int busy_cyc, output int en_cyc);
    int nrd;
    nrd = 0; done_cyc = 0; busy_cyc = 0; en_cyc = 0;
    rd_addrs.delete();
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; word_count = n;
    @(negedge clk);
    start = 1'b0; src_addr = 32'h0; dst_addr = 32'h0; word_count = 16'h0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (cyc > 1) @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      if (busy) busy_cyc++;
      if (mem_enable) en_cyc++;
      if (mem_enable && !mem_wr) begin
        rd_addrs.push_back(mem_addr);
        nrd++;
        if (nrd == abort_rd) abort = 1'b1;
      end
      if (poke && cyc == 3) begin
        start = 1'b1; src_addr = 32'h100; dst_addr = 32'h280; word_count = 16'd8;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    start = 1'b0; abort = 1'b0;
    if (done_cyc == 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  int dc, bc, ec;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; word_count = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD0000 | i;
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_en", {31'b0, mem_enable}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wc", {16'b0, words_copied}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // 1: basic 4-word copy
    mem[64] = 32'h11111111; mem[65] = 32'h22222222; mem[66] = 32'h33333333; mem[67] = 32'h44444444;
    run(32'h100, 32'h200, 16'd4, 0, 1'b0, dc, bc, ec);
    chk("t1_done_cyc", dc, 32'd9);
    chk("t1_busy_cyc", bc, 32'd8);
    chk("t1_w0", rdm(32'h200), 32'h11111111);
    chk("t1_w1", rdm(32'h204), 32'h22222222);
    chk("t1_w2", rdm(32'h208), 32'h33333333);
    chk("t1_w3", rdm(32'h20C), 32'h44444444);
    chk("t1_past", rdm(32'h210), 32'hDEAD0084);
    chk("t1_wc", {16'b0, words_copied}, 32'd4);
    @(negedge clk);
    chk("t1_wc_hold", {16'b0, words_copied}, 32'd4);
    chk("t1_idle_busy", {31'b0, busy}, 32'd0);

    // 2: zero-length copy
    run(32'h100, 32'h220, 16'd0, 0, 1'b0, dc, bc, ec);
    chk("t2_done_cyc", dc, 32'd1);
    chk("t2_en_cyc", ec, 32'd0);
    chk("t2_wc", {16'b0, words_copied}, 32'd0);

    // 3: abort during 3rd read
    for (int i = 0; i < 8; i++) begin mem[80 + i] = 32'hA0000000 + i; mem[144 + i] = 32'h0; end
    run(32'h140, 32'h240, 16'd8, 3, 1'b0, dc, bc, ec);
    chk("t3_done_cyc", dc, 32'd6);
    chk("t3_busy_cyc", bc, 32'd5);
    chk("t3_wc", {16'b0, words_copied}, 32'd2);
    chk("t3_w0", rdm(32'h240), 32'hA0000000);
    chk("t3_w1", rdm(32'h244), 32'hA0000001);
    chk("t3_w2", rdm(32'h248), 32'h0);
    chk("t3_w3", rdm(32'h24C), 32'h0);

    // 4: source wraps through zero; start pulsed mid-copy
    mem[1023] = 32'hA5A5A5A5; mem[0] = 32'h5A5A5A5A;
    run(32'hFFFFFFFC, 32'h300, 16'd2, 0, 1'b1, dc, bc, ec);
    chk("t4_nrd", rd_addrs.size(), 32'd2);
    chk("t4_rd0", (rd_addrs.size() > 0) ? rd_addrs[0] : 32'hX, 32'hFFFFFFFC);
    chk("t4_rd1", (rd_addrs.size() > 1) ? rd_addrs[1] : 32'hX, 32'h00000000);
    chk("t4_done_cyc", dc, 32'd5);
    chk("t4_wc", {16'b0, words_copied}, 32'd2);
    chk("t4_w0", rdm(32'h300), 32'hA5A5A5A5);
    chk("t4_w1", rdm(32'h304), 32'h5A5A5A5A);
    chk("t4_noclobber", rdm(32'h280), 32'hDEAD00A0);
    @(negedge clk);
    chk("t4_idle", {31'b0, busy}, 32'd0);

    // 5: overlapping forward copy smears the first word
    mem[64] = 32'h11111111; mem[65] = 32'h22222222; mem[66] = 32'h33333333; mem[67] = 32'h44444444;
    run(32'h100, 32'h104, 16'd3, 0, 1'b0, dc, bc, ec);
    chk("t5_w0", rdm(32'h100), 32'h11111111);
    chk("t5_w1", rdm(32'h104), 32'h11111111);
    chk("t5_w2", rdm(32'h108), 32'h11111111);
    chk("t5_w3", rdm(32'h10C), 32'h11111111);

    // 6: async reset in the middle of a write
    @(negedge clk);
    start = 1'b1; src_addr = 32'h100; dst_addr = 32'h380; word_count = 16'd4;
    @(negedge clk); start = 1'b0;
    begin
      int guard = 0;
      while (!mem_wr && guard < 20) begin @(negedge clk); guard++; end
      chk("t6_saw_write", {31'b0, mem_wr}, 32'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", {31'b0, busy}, 32'd0);
    chk("t6_en", {31'b0, mem_enable}, 32'd0);
    chk("t6_wr", {31'b0, mem_wr}, 32'd0);
    chk("t6_addr", mem_addr, 32'd0);
    chk("t6_wdata", mem_data_in, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("t6_post_idle", {31'b0, busy}, 32'd0);
    run(32'h100, 32'h3C0, 16'd1, 0, 1'b0, dc, bc, ec);
    chk("t6_done_cyc", dc, 32'd3);
    chk("t6_dump", {31'b0, mem_createdump}, 32'd1);
    @(negedge clk);
    chk("t6_dump_off", {31'b0, mem_createdump}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
